// File: rtl/coincidence_trigger_pkg.sv
// Shared definitions for the coincidence trigger blocks:
// FSM state encodings and a popcount helper.
package coincidence_trigger_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FIRE  = 2'd2;
  localparam logic [1:0] ST_DEAD  = 2'd3;

  // Widest channel vector popcount accepts; callers zero-extend.
  localparam int MAX_CH = 256;

  function automatic int unsigned popcount(
    input logic [MAX_CH-1:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CH; i++)
      n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/coincidence_trigger_stretcher.sv
// One channel: rising-edge detect plus WINDOW-cycle gate counter.
// Ports: clk, rst (sync, high), clr (hold gate at 0), in, en, active.
module coincidence_trigger_stretcher
  import coincidence_trigger_pkg::*;
#(
  parameter int WINDOW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in,
  input  logic en,
  output logic active
);

  localparam int GW = $clog2(WINDOW + 1);

  logic          prev;
  logic [GW-1:0] gcnt;

  // prev tracks the input in every state so an edge seen
  // while the gate is cleared cannot appear later.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      gcnt <= '0;
    end else begin
      prev <= in;
      if (clr)
        gcnt <= '0;
      else if (en && in && !prev)
        gcnt <= GW'(WINDOW);
      else if (gcnt != '0)
        gcnt <= gcnt - 1'b1;
    end
  end

  assign active = (gcnt != '0);

endmodule

// File: rtl/coincidence_trigger.sv
// N-channel coincidence trigger: gates, threshold FSM, deadtime, counter.
// Ports: clk, rst, triggers, chmask, threshold, enable, count_clr ->
//        triggered, armed, busy, hitpattern, trig_count.
module coincidence_trigger
  import coincidence_trigger_pkg::*;
#(
  parameter int NCH      = 16,
  parameter int WINDOW   = 4,
  parameter int DEADTIME = 16,
  parameter int CNTW     = 16,
  parameter int THRW     = $clog2(NCH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  triggers,
  input  logic [NCH-1:0]  chmask,
  input  logic [THRW-1:0] threshold,
  input  logic            enable,
  input  logic            count_clr,
  output logic            triggered,
  output logic            armed,
  output logic            busy,
  output logic [NCH-1:0]  hitpattern,
  output logic [CNTW-1:0] trig_count
);

  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DW-1:0] DLOAD =
    DW'((DEADTIME > 0) ? DEADTIME - 1 : 0);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DW-1:0]     dcnt;
  logic [NCH-1:0]    active;
  logic [MAX_CH-1:0] active_ext;
  logic [THRW-1:0]   mult;
  logic              fire_go;
  logic              gate_clr;

  // Gates only run while ARMED; FIRE and DEAD discard edges.
  assign gate_clr = (state != ST_ARMED);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    coincidence_trigger_stretcher #(
      .WINDOW(WINDOW)
    ) u_str (
      .clk   (clk),
      .rst   (rst),
      .clr   (gate_clr),
      .in    (triggers[i]),
      .en    (chmask[i]),
      .active(active[i])
    );
  end

  always_comb begin
    active_ext = '0;
    active_ext[NCH-1:0] = active;
  end

  assign mult    = THRW'(popcount(active_ext));
  assign fire_go = (threshold != '0) && (mult >= threshold);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  state_nxt = ST_ARMED;
      ST_ARMED: if (fire_go) state_nxt = ST_FIRE;
      ST_FIRE:  state_nxt = (DEADTIME == 0) ? ST_ARMED : ST_DEAD;
      ST_DEAD:  if (dcnt == '0) state_nxt = ST_ARMED;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!enable)
      state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dcnt       <= '0;
      hitpattern <= '0;
      trig_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FIRE)
        dcnt <= DLOAD;
      else if (state == ST_DEAD && dcnt != '0)
        dcnt <= dcnt - 1'b1;
      // Capture the gates that formed the coincidence, before
      // the oldest one can expire during the FIRE cycle.
      if (state == ST_ARMED && state_nxt == ST_FIRE)
        hitpattern <= active;
      if (count_clr)
        trig_count <= '0;
      else if (state == ST_FIRE && trig_count != '1)
        trig_count <= trig_count + 1'b1;
    end
  end

  assign triggered = (state == ST_FIRE);
  assign armed     = (state == ST_ARMED);
  assign busy      = (state == ST_FIRE) || (state == ST_DEAD);

endmodule
